// File: rtl/counter_ud_param.sv
// counter_ud_param
//
// Parametrised up/down counter with wrap or saturate boundary handling,
// synchronous clear and parallel load, a registered terminal-count pulse
// and a sticky overflow flag.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  upper bound of the count range (lower bound is 0)
//   WRAP     1 = wrap around at the bounds, 0 = saturate at the bounds
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   clear        synchronous clear of count, tc and ovf
//   load         synchronous parallel load (clamped to MAX_VAL)
//   load_val     value taken when load = 1
//   enable       count enable
//   dir          1 = count up, 0 = count down
//   counter_out  current count (registered)
//   at_max       high while counter_out == MAX_VAL
//   at_min       high while counter_out == 0
//   tc           one-cycle pulse after an attempted boundary crossing
//   ovf          sticky: a boundary crossing happened since reset/clear
module counter_ud_param #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter bit              WRAP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             dir,
    output logic [WIDTH-1:0] counter_out,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_W};

    // Out-of-range load values are pinned to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        if ({1'b0, val} > MAX_EXT) begin
            return MAX_W;
        end
        return val;
    endfunction

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_next;

    // One extra bit of headroom: the increment is compared against MAX_VAL
    // rather than relying on binary rollover, so non-power-of-two ranges
    // wrap correctly; the decrement's borrow bit flags the lower bound.
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic           up_over;
    logic           dn_under;

    assign up_sum   = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign dn_diff  = {1'b0, count} - {{WIDTH{1'b0}}, 1'b1};
    assign up_over  = (up_sum > MAX_EXT);
    assign dn_under = dn_diff[WIDTH];

    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        ovf_next   = ovf;
        if (clear) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = clamp_load(load_val);
        end else if (enable) begin
            if (dir) begin
                if (up_over) begin
                    count_next = WRAP ? '0 : MAX_W;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = up_sum[WIDTH-1:0];
                end
            end else begin
                if (dn_under) begin
                    count_next = WRAP ? MAX_W : '0;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = dn_diff[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
            ovf   <= ovf_next;
        end
    end

    assign counter_out = count;
    assign at_max      = (count == MAX_W);
    assign at_min      = (count == '0);

endmodule

// File: doc/counter_ud_param.md
# counter_ud_param

Parametrised up/down counter: the next generation of the Ex3 8-bit up/down counter. It adds configurable width and terminal value, wrap or saturate mode, synchronous clear and parallel load, registered terminal-count pulse and sticky overflow flag. It is a standalone building block for later exercises that need timers, address generators or bounded event counters.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, upper bound of the count range. Lower bound is 0. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- WRAP, 1, boundary mode. 1 = wrap (MAX_VAL+1 -> 0, 0-1 -> MAX_VAL). 0 = saturate (hold at bound).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst = 0 resets immediately, independent of clk).
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value taken when load = 1.
- enable  in  1  count enable.
- dir  in  1  1 = count up, 0 = count down.
- counter_out  out  WIDTH  current count (registered).
- at_max  out  1  high while counter_out == MAX_VAL.
- at_min  out  1  high while counter_out == 0.
- tc  out  1  one-cycle pulse when a boundary crossing was attempted on the last edge.
- ovf  out  1  sticky flag: at least one boundary crossing since the last reset or clear.

## Operation
- Reset (rst = 0): counter_out = 0, tc = 0, ovf = 0. Consequently at_min = 1 and at_max = 0 (at_max = 1 only if MAX_VAL = 0, which is illegal).
- Per-edge priority, highest first: clear > load > enable > hold.
  - clear = 1: counter_out <= 0, tc <= 0, ovf <= 0.
  - load = 1: counter_out <= min(load_val, MAX_VAL), so out-of-range values are clamped. tc <= 0. ovf is unchanged.
  - enable = 1, dir = 1:
    - counter_out < MAX_VAL: increment.
    - counter_out == MAX_VAL: boundary. Goes to 0 if WRAP = 1; holds MAX_VAL if WRAP = 0.
  - enable = 1, dir = 0:
    - counter_out > 0: decrement.
    - counter_out == 0: boundary. Goes to MAX_VAL if WRAP = 1; holds 0 if WRAP = 0.
  - enable = 0: hold. tc <= 0.
- Boundary event (enable = 1, no clear or load, at the bound in the direction of travel):
  - tc <= 1 for exactly one cycle; ovf <= 1.
  - This happens in both WRAP modes. In saturate mode tc repeats every cycle the counter stays pinned with enable held.
- Arithmetic is done at WIDTH+1 bits internally. The comparison against MAX_VAL prevents natural binary rollover, so a non-power-of-two MAX_VAL (e.g. 9) wraps correctly.
- at_max and at_min are pure decodes of the counter register: no added latency, no glitch requirement beyond normal synchronous use.
- dir may change on any cycle. The direction is sampled on the same edge as enable; there is no turnaround penalty.

## Timing
- Latency is one cycle: inputs sampled on edge N appear on counter_out, tc and ovf after edge N.
- Reset assertion is asynchronous. Deassertion should be synchronised externally; the first count can occur on the first rising edge with rst = 1.
- Reset asserted mid-count overrides everything immediately, including a pending tc.
- Simultaneous clear + load + enable: clear wins, giving 0 with ovf cleared. load + enable: load wins with no count applied.
- For bench checks, sample outputs away from the active edge (e.g. 4 ns after posedge at CLK_PERIOD = 10 ns).

## Test plan
- Reset/hold: WIDTH = 8, assert rst = 0 mid-count at 0x37. Expect counter_out = 0, at_min = 1, ovf = 0 immediately, before the next edge. Then with enable = 0 for 5 cycles the count stays 0.
- Up-wrap: WIDTH = 4, MAX_VAL = 9, WRAP = 1, enable = 1, dir = 1 from 0. Expect the sequence 1..9, then 0. tc = 1 for the single cycle after the 9 -> 0 edge; ovf = 1 afterwards and stays 1.
- Down-wrap: same config, dir = 0 from 0. Expect 9, 8, ...; tc pulses on the 0 -> 9 transition.
- Saturate: WIDTH = 8, WRAP = 0, load 0xFE then count up 3 cycles. Expect 0xFF, 0xFF, 0xFF, at_max = 1, and tc high on the 2nd and 3rd cycles. Then dir = 0 for 1 cycle gives 0xFE with tc = 0.
- Load clamp and priority: MAX_VAL = 9, load_val = 12 with load = 1 and enable = 1 gives counter_out = 9. Then clear = 1 and load = 1 together give counter_out = 0, ovf = 0.
- Direction toggling: WIDTH = 8 starting at 5, with dir pattern 1, 1, 0, 1, 0, 0 and enable = 1. Expect 6, 7, 6, 7, 6, 5, with tc = 0 throughout.
